// File: rtl/fifo_stream_reader_pkg.sv
// fifo_pkg: constants and helpers shared by the FIFO read-side stream logic.
//   RD_BUF_DEPTH : depth of the holding buffer behind the FIFO read port.
//   clog2_min1   : ceil(log2(n)), never less than 1. Used to size counters so
//                  that a 1-state counter still has a legal width.
package fifo_pkg;

  localparam int RD_BUF_DEPTH = 2;

  function automatic int clog2_min1(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus the outgoing valid/ready stream.
//   FIFO side   : fifo_empty, fifo_data (in to reader), fifo_cs, fifo_rd_en (out of reader)
//   Stream side : out_valid, out_data, out_last (out of reader), out_ready (in to reader)
//   master      : the reader (fifo_stream_reader)
//   slave       : the environment (FIFO + downstream consumer)
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_cs;
  logic                  fifo_rd_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_cs, fifo_rd_en, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_cs, fifo_rd_en, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_stream_reader_buf.sv
// stream_buf2: 2-entry holding buffer with a combinational head.
//   clk, rst : clock, synchronous active-high reset (clears entries and count)
//   wr_en    : push wr_data at the tail
//   rd_en    : pop the head (caller guarantees count != 0)
//   rd_data  : current head entry
//   count    : number of occupied entries (0..2)
// Push and pop may happen in the same cycle.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [RD_BUF_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < RD_BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  assign rd_data = mem[rd_ptr];

  // A push into a full buffer without a pop would overwrite the head.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !rd_en && count == 2'd2));

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (1-cycle registered read)
// onto a valid/ready stream at up to 1 word/clk, marking packet boundaries.
//   clk, rst  : single clock, synchronous active-high reset
//   drain_en  : permits new FIFO reads; words already read are still delivered
//   bus       : FIFO read port + output stream (master side)
//   busy      : buffer occupied or a read is in flight
// Reads are issued only when the word will have a buffer slot on arrival, so
// occupancy + in-flight never exceeds the buffer depth even under backpressure.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 drain_en,
  fifo_stream_reader_if.master bus,
  output logic                 busy
);

  localparam int                 CNT_W     = clog2_min1(PKT_LEN);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic                  inflight;
  logic                  pop;
  logic                  rd_en;
  logic [1:0]            occ;
  logic [2:0]            level_next;
  logic [CNT_W-1:0]      beat_cnt;
  logic [DATA_WIDTH-1:0] head;

  assign pop = bus.out_valid & bus.out_ready;

  // Buffer level after this cycle's capture/pop, before counting a new read.
  assign level_next = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en      = !rst && drain_en && !bus.fifo_empty
                      && (level_next < 3'(RD_BUF_DEPTH));

  assign bus.fifo_rd_en = rd_en;
  assign bus.fifo_cs    = rd_en;

  // FIFO data_out is valid the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= rd_en;
  end

  stream_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (bus.fifo_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (occ)
  );

  always_ff @(posedge clk) begin
    if (rst)      beat_cnt <= '0;
    else if (pop) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
  end

  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = head;
  assign bus.out_last  = bus.out_valid && (beat_cnt == LAST_BEAT);
  assign busy          = (occ != 2'd0) || inflight;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  localparam int DW      = 32;
  localparam int PKT_LEN = 8;

  logic          clk = 1'b0;
  logic          rst, fifo_rst, drain_en, busy, wr_req;
  logic [DW-1:0] wr_val;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PKT_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .drain_en (drain_en),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: registered data_out, 1-cycle read latency.
  logic [DW-1:0] mem [0:4095];
  int            wp = 0, rp = 0;
  logic [DW-1:0] fdata = '0;

  always @(posedge clk) begin
    if (fifo_rst) begin
      wp <= 0; rp <= 0; fdata <= '0;
    end else begin
      if (bus.fifo_rd_en) begin
        fdata <= mem[rp[11:0]];
        rp    <= rp + 1;
      end
      if (wr_req) begin
        mem[wp[11:0]] <= wr_val;
        wp            <= wp + 1;
      end
    end
  end

  assign bus.fifo_empty = (wp == rp);
  assign bus.fifo_data  = fdata;

  // Reference model: words enter in write order and leave in the same order;
  // every PKT_LEN-th accepted word since reset closes a packet.
  logic [DW-1:0] exp_q[$];
  int            beat;
  int            checks = 0, failures = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pop(output logic [DW-1:0] d, output logic l, output bit ok);
    ok = (exp_q.size() != 0);
    d  = '0;
    l  = (beat == PKT_LEN - 1);
    if (ok) d = exp_q.pop_front();
    beat = (beat + 1) % PKT_LEN;
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_rst = 1'b1; wr_req = 1'b0; bus.out_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0; fifo_rst = 1'b0;
    exp_q.delete();
    beat = 0;
  endtask

  task automatic load(input int n, input bit seq);
    for (int i = 0; i < n; i++) begin
      wr_req = 1'b1;
      wr_val = seq ? DW'(i) : DW'($urandom);
      exp_q.push_back(wr_val);
      next_cycle();
    end
    wr_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drain_en = 1'b0;
    load(3, 1'b0);
    rst = 1'b1; drain_en = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks += 5;
      if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
      if (bus.fifo_cs !== 1'b0)    begin failures++; $display("FAIL reset_cs: got %b want 0", bus.fifo_cs); end
      if (bus.out_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      if (bus.out_data !== '0)     begin failures++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
      if (busy !== 1'b0)           begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      next_cycle();
    end
    drain_en = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    int rcnt = 0, vcnt = 0, rfirst = -1, vfirst = -1;
    logic [DW-1:0] ed; logic el; bit ok;
    do_reset();
    drain_en = 1'b1; bus.out_ready = 1'b1;
    wr_req = 1'b1; wr_val = 32'hA5A5_0001; exp_q.push_back(wr_val);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) begin rcnt++; if (rfirst < 0) rfirst = c; end
      if (bus.out_valid) begin
        vcnt++; if (vfirst < 0) vfirst = c;
        model_pop(ed, el, ok);
        checks++;
        if (!ok || bus.out_data !== ed) begin
          failures++; $display("FAIL single_data: got %h want %h", bus.out_data, ed);
        end
      end
      next_cycle();
      wr_req = 1'b0;
    end
    checks += 4;
    if (rcnt != 1)            begin failures++; $display("FAIL single_reads: got %0d want 1", rcnt); end
    if (vcnt != 1)            begin failures++; $display("FAIL single_valid_cycles: got %0d want 1", vcnt); end
    if (vfirst - rfirst != 2) begin failures++; $display("FAIL single_latency: got %0d want 2", vfirst - rfirst); end
    if (rp != 1)              begin failures++; $display("FAIL single_read_ptr: got %0d want 1", rp); end
  endtask

  task automatic test_streaming();
    int nv = 0, first_v = -1, last_v = -1, nlast = 0;
    logic [DW-1:0] ed; logic el; bit ok;
    do_reset();
    drain_en = 1'b0;
    load(16, 1'b1);
    drain_en = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        nv++; if (first_v < 0) first_v = c; last_v = c;
        if (bus.out_last) nlast++;
        model_pop(ed, el, ok);
        checks++;
        if (!ok || bus.out_data !== ed || bus.out_last !== el) begin
          failures++;
          $display("FAIL stream_beat: got data=%h last=%b want data=%h last=%b", bus.out_data, bus.out_last, ed, el);
        end
      end
      next_cycle();
    end
    checks += 3;
    if (nv != 16)              begin failures++; $display("FAIL stream_count: got %0d want 16", nv); end
    if (last_v - first_v != 15) begin failures++; $display("FAIL stream_back_to_back: span %0d want 15", last_v - first_v); end
    if (nlast != 2)            begin failures++; $display("FAIL stream_last_count: got %0d want 2", nlast); end
  endtask

  task automatic test_backpressure();
    int reads = 0, got = 0;
    logic [DW-1:0] ed; logic el; bit ok;
    do_reset();
    drain_en = 1'b0;
    load(10, 1'b0);
    drain_en = 1'b1; bus.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) reads++;
      if (bus.out_valid) begin
        checks++;
        if (bus.out_data !== exp_q[0] || bus.out_last !== 1'b0) begin
          failures++;
          $display("FAIL bp_hold: got data=%h last=%b want data=%h last=0", bus.out_data, bus.out_last, exp_q[0]);
        end
      end
      next_cycle();
    end
    checks += 2;
    if (reads != 2)           begin failures++; $display("FAIL bp_reads: got %0d want 2", reads); end
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got++;
        model_pop(ed, el, ok);
        checks++;
        if (!ok || bus.out_data !== ed || bus.out_last !== el) begin
          failures++;
          $display("FAIL bp_release: got data=%h last=%b want data=%h last=%b", bus.out_data, bus.out_last, ed, el);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks += 2;
    if (got != 10)              begin failures++; $display("FAIL bp_delivered: got %0d want 10", got); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup: out_valid %b want 0", bus.out_valid); end
    next_cycle();
  endtask

  task automatic test_drain();
    int reads = 0, got = 0;
    logic [DW-1:0] ed; logic el; bit ok;
    do_reset();
    drain_en = 1'b0;
    load(12, 1'b0);
    drain_en = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && reads < 4; c++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) reads++;
      if (bus.out_valid) begin
        got++; model_pop(ed, el, ok); checks++;
        if (!ok || bus.out_data !== ed) begin failures++; $display("FAIL drain_data: got %h want %h", bus.out_data, ed); end
      end
      next_cycle();
    end
    drain_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL drain_stop: rd_en %b want 0", bus.fifo_rd_en); end
      if (bus.out_valid) begin
        got++; model_pop(ed, el, ok); checks++;
        if (!ok || bus.out_data !== ed) begin failures++; $display("FAIL drain_flush: got %h want %h", bus.out_data, ed); end
      end
      next_cycle();
    end
    @(negedge clk);
    checks += 2;
    if (got != 4)      begin failures++; $display("FAIL drain_delivered: got %0d want 4", got); end
    if (busy !== 1'b0) begin failures++; $display("FAIL drain_busy: got %b want 0", busy); end
    next_cycle();
    drain_en = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got++; model_pop(ed, el, ok); checks++;
        if (!ok || bus.out_data !== ed) begin failures++; $display("FAIL drain_resume: got %h want %h", bus.out_data, ed); end
      end
      next_cycle();
    end
    checks++;
    if (got != 12) begin failures++; $display("FAIL drain_total: got %0d want 12", got); end
  endtask

  task automatic test_random();
    int written = 0;
    bit rst_done = 0, done = 0, in_rst, hold = 0;
    logic [DW-1:0] hold_d, ed; logic hold_l, el; bit ok;
    do_reset();
    drain_en = 1'b1;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      in_rst = !rst_done && written >= 500;
      if (in_rst) begin
        rst = 1'b1; fifo_rst = 1'b1; wr_req = 1'b0; bus.out_ready = 1'b0;
        exp_q.delete(); beat = 0; rst_done = 1; hold = 0;
      end else begin
        rst = 1'b0; fifo_rst = 1'b0;
        bus.out_ready = 1'($urandom_range(0, 1));
        wr_req = (written < 1000) && ($urandom_range(0, 1) == 1);
        if (wr_req) begin
          wr_val = DW'($urandom); exp_q.push_back(wr_val); written++;
        end
      end
      @(negedge clk);
      if (!in_rst) begin
        checks++;
        if ((bus.fifo_rd_en && bus.fifo_empty) || bus.fifo_cs !== bus.fifo_rd_en) begin
          failures++;
          $display("FAIL rnd_issue: rd_en=%b cs=%b empty=%b", bus.fifo_rd_en, bus.fifo_cs, bus.fifo_empty);
        end
        if (hold) begin
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== hold_d || bus.out_last !== hold_l) begin
            failures++;
            $display("FAIL rnd_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     bus.out_valid, bus.out_data, bus.out_last, hold_d, hold_l);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          model_pop(ed, el, ok); checks++;
          if (!ok || bus.out_data !== ed || bus.out_last !== el) begin
            failures++;
            $display("FAIL rnd_beat: got d=%h l=%b want d=%h l=%b", bus.out_data, bus.out_last, ed, el);
          end
        end
        hold = bus.out_valid && !bus.out_ready;
        hold_d = bus.out_data; hold_l = bus.out_last;
        done = (written == 1000) && (exp_q.size() == 0) && !busy;
      end
      next_cycle();
    end
    rst = 1'b0; fifo_rst = 1'b0; wr_req = 1'b0;
    checks++;
    if (!done) begin failures++; $display("FAIL rnd_timeout: written=%0d pending=%0d want 1000/0", written, exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; fifo_rst = 1'b1; drain_en = 1'b0; wr_req = 1'b0; wr_val = '0;
    bus.out_ready = 1'b0; beat = 0;
    next_cycle();
    next_cycle();
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
